// File: rtl/dma_priority_control_if.sv
// ---------------------------------------------------------------------------
// dma_priority_control_if
// Bus bundle between the CPU/channel side and the DMA priority controller.
//   master : drives channel requests, HLDA, register values and TC;
//            observes HRQ, DACKs, AEN, strobes, active_channel and state.
//   slave  : the controller (mirror image of master).
// ---------------------------------------------------------------------------
interface dma_priority_control_if;
  logic       DREQ0, DREQ1, DREQ2, DREQ3;
  logic       HLDA;
  logic [7:0] commandReg;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic [7:0] mode_register;
  logic       TC;
  logic       HRQ;
  logic       DACK0, DACK1, DACK2, DACK3;
  logic       AEN;
  logic       MEMR, MEMW, IOR, IOW;
  logic [1:0] active_channel;
  logic [2:0] state;

  modport master (
    output DREQ0, DREQ1, DREQ2, DREQ3, HLDA, commandReg, maskReg,
           requestReg, mode_register, TC,
    input  HRQ, DACK0, DACK1, DACK2, DACK3, AEN, MEMR, MEMW, IOR, IOW,
           active_channel, state
  );

  modport slave (
    input  DREQ0, DREQ1, DREQ2, DREQ3, HLDA, commandReg, maskReg,
           requestReg, mode_register, TC,
    output HRQ, DACK0, DACK1, DACK2, DACK3, AEN, MEMR, MEMW, IOR, IOW,
           active_channel, state
  );
endinterface

// File: rtl/dma_priority_control.sv
// ---------------------------------------------------------------------------
// dma_priority_control
// Four-channel DMA request arbiter and bus-cycle sequencer.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : dma_priority_control_if.slave (requests, HLDA, registers, TC in;
//           HRQ, DACK0..3, AEN, MEMR/MEMW/IOR/IOW, active_channel, state out)
// Every output is a flop, computed from the next-state value so that it
// lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module dma_priority_control (
  input  logic                         clk,
  input  logic                         rst_n,
  dma_priority_control_if.slave        bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S0   = 3'd1;
  localparam logic [2:0] ST_S1   = 3'd2;
  localparam logic [2:0] ST_S2   = 3'd3;
  localparam logic [2:0] ST_S3   = 3'd4;
  localparam logic [2:0] ST_S4   = 3'd5;

  localparam logic [1:0] TYPE_WRITE = 2'b01;
  localparam logic [1:0] TYPE_READ  = 2'b10;

  // Return the requesting channel closest to 'top' going upward mod 4.
  function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                             input logic [1:0] top);
    logic [1:0] idx;
    pick_winner = top;
    for (int i = 3; i >= 0; i--) begin
      idx = top + i[1:0];
      if (req[idx]) pick_winner = idx;
    end
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] ch);
    onehot4 = 4'b0001 << ch;
  endfunction

  logic [2:0] state_r, next_state_s;
  logic [1:0] active_r, next_active_s;
  logic [1:0] prio_r, next_prio_s;
  logic [3:0] dreq_s, req_s;
  logic       any_req_s, end_s;
  logic [1:0] winner_s, xfer_type_s;
  logic       hrq_r, aen_r, memr_r, memw_r, ior_r, iow_r;
  logic [3:0] dack_r;
  logic       unused_bits_s;

  assign dreq_s      = {bus.DREQ3, bus.DREQ2, bus.DREQ1, bus.DREQ0};
  assign req_s       = bus.commandReg[2] ? 4'b0000
                       : ((dreq_s & ~bus.maskReg) | bus.requestReg);
  assign any_req_s   = |req_s;
  assign winner_s    = pick_winner(req_s, bus.commandReg[4] ? prio_r : 2'd0);
  assign xfer_type_s = bus.mode_register[3:2];
  assign unused_bits_s = ^{bus.commandReg[7:5], bus.commandReg[3],
                           bus.commandReg[1:0], bus.mode_register[5:4],
                           bus.mode_register[1:0]};

  // Next-state, channel latch and end-of-service detection.
  always_comb begin
    next_state_s  = state_r;
    next_active_s = active_r;
    end_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) next_state_s = ST_S0;
        else           next_state_s = ST_IDLE;
      end
      ST_S0: begin
        if (!any_req_s) begin
          next_state_s = ST_IDLE;
        end else if (bus.HLDA) begin
          next_state_s  = ST_S1;
          next_active_s = winner_s;
        end else begin
          next_state_s = ST_S0;
        end
      end
      ST_S1, ST_S2, ST_S3: begin
        if (!bus.HLDA) begin
          next_state_s = ST_IDLE;
          end_s        = 1'b1;
        end else begin
          next_state_s = state_r + 3'd1;
        end
      end
      ST_S4: begin
        // Disable only takes effect here, so an in-flight transfer finishes.
        if (!bus.HLDA || bus.TC || bus.commandReg[2]) begin
          next_state_s = ST_IDLE;
          end_s        = 1'b1;
        end else begin
          case (bus.mode_register[7:6])
            2'b00: begin
              if (dreq_s[active_r] && !bus.maskReg[active_r]) begin
                next_state_s = ST_S2;
              end else begin
                next_state_s = ST_IDLE;
                end_s        = 1'b1;
              end
            end
            2'b10:   next_state_s = ST_S2;
            default: begin
              next_state_s = ST_IDLE;
              end_s        = 1'b1;
            end
          endcase
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Rotating pointer: serviced channel drops to lowest once its service ends.
  always_comb begin
    if (end_s && bus.commandReg[4]) next_prio_s = active_r + 2'd1;
    else                            next_prio_s = prio_r;
  end

  // State, channel, pointer and all output flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      active_r <= 2'd0;
      prio_r   <= 2'd0;
      hrq_r    <= 1'b0;
      aen_r    <= 1'b0;
      dack_r   <= 4'b0000;
      memr_r   <= 1'b0;
      memw_r   <= 1'b0;
      ior_r    <= 1'b0;
      iow_r    <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      active_r <= next_active_s;
      prio_r   <= next_prio_s;
      hrq_r    <= (next_state_s != ST_IDLE);
      aen_r    <= (next_state_s >= ST_S1) && (next_state_s <= ST_S4);
      dack_r   <= ((next_state_s >= ST_S2) && (next_state_s <= ST_S4))
                  ? onehot4(next_active_s) : 4'b0000;
      // Read-side strobe spans S2..S3, write-side strobe is S3 only.
      memr_r   <= ((next_state_s == ST_S2) || (next_state_s == ST_S3))
                  && (xfer_type_s == TYPE_READ);
      ior_r    <= ((next_state_s == ST_S2) || (next_state_s == ST_S3))
                  && (xfer_type_s == TYPE_WRITE);
      memw_r   <= (next_state_s == ST_S3) && (xfer_type_s == TYPE_WRITE);
      iow_r    <= (next_state_s == ST_S3) && (xfer_type_s == TYPE_READ);
    end
  end

  assign bus.state          = state_r;
  assign bus.active_channel = active_r;
  assign bus.HRQ            = hrq_r;
  assign bus.AEN            = aen_r;
  assign bus.DACK0          = dack_r[0];
  assign bus.DACK1          = dack_r[1];
  assign bus.DACK2          = dack_r[2];
  assign bus.DACK3          = dack_r[3];
  assign bus.MEMR           = memr_r;
  assign bus.MEMW           = memw_r;
  assign bus.IOR            = ior_r;
  assign bus.IOW            = iow_r;

endmodule

// File: tb/tb_dma_priority_control.sv
// ---------------------------------------------------------------------------
// tb_dma_priority_control
// Directed scenarios; each pushes the transfer cycles it expects into a
// queue, and a negedge monitor pops one entry for every cycle a DACK is high.
// ---------------------------------------------------------------------------
module tb_dma_priority_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  dma_priority_control_if bus();

  dma_priority_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] dack;
    logic [1:0] ch;
    logic [3:0] strb;   // {MEMR, MEMW, IOR, IOW}
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [3:0] dack_obs, strb_obs;
  assign dack_obs = {bus.DACK3, bus.DACK2, bus.DACK1, bus.DACK0};
  assign strb_obs = {bus.MEMR, bus.MEMW, bus.IOR, bus.IOW};

  // ty: 1 = write (IOR then MEMW), 2 = read (MEMR then IOW)
  task automatic push_xfer(input int ch, input int ty, input int n_states);
    exp_t e;
    e.ch   = ch[1:0];
    e.dack = 4'b0001 << ch;
    e.st = 3'd3; e.strb = {ty == 2, 1'b0, ty == 1, 1'b0};
    if (n_states >= 1) exp_q.push_back(e);
    e.st = 3'd4; e.strb = {ty == 2, ty == 1, ty == 1, ty == 2};
    if (n_states >= 2) exp_q.push_back(e);
    e.st = 3'd5; e.strb = 4'b0000;
    if (n_states >= 3) exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit);
    int n = 0;
    while (bus.state !== st && n < limit) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("wait_state_%0d", st), {31'd0, bus.state === st}, 32'd1);
  endtask

  task automatic wait_dack(input int ch, input int limit);
    int n = 0;
    while (dack_obs[ch] !== 1'b1 && n < limit) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("wait_dack_%0d", ch), {31'd0, dack_obs[ch] === 1'b1}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!(exp_q.size() == 0 && bus.state === 3'd0) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_idle"}, {29'd0, bus.state}, 32'd0);
  endtask

  // Scoreboard monitor: one expected entry per DACK-active cycle.
  always @(negedge clk) begin
    exp_t e;
    if (dack_obs != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected: got st=%0d dack=%b ch=%0d strb=%b, expected none",
                 bus.state, dack_obs, bus.active_channel, strb_obs);
      end else begin
        e = exp_q.pop_front();
        if ({bus.state, dack_obs, bus.active_channel, strb_obs} !== e) begin
          failures++;
          $display("FAIL xfer: got st=%0d dack=%b ch=%0d strb=%b, expected st=%0d dack=%b ch=%0d strb=%b",
                   bus.state, dack_obs, bus.active_channel, strb_obs,
                   e.st, e.dack, e.ch, e.strb);
        end
      end
    end
  end

  task automatic set_dreq(input logic [3:0] v);
    {bus.DREQ3, bus.DREQ2, bus.DREQ1, bus.DREQ0} = v;
  endtask

  initial begin
    int n;
    int s4;
    set_dreq(4'b0000);
    bus.HLDA = 1'b1; bus.commandReg = 8'h00; bus.maskReg = 4'h0;
    bus.requestReg = 4'h0; bus.mode_register = 8'h44; bus.TC = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.HRQ, bus.AEN, dack_obs, strb_obs, bus.state,
                            bus.active_channel}, 32'd0);
    rst_n = 1'b1;

    // Fixed priority: channel 1 beats 3, then 3 after 1 drops.
    set_dreq(4'b1010);
    push_xfer(1, 1, 3); push_xfer(3, 1, 3);
    @(posedge clk); #1;
    check("hrq_after_1clk", {28'd0, bus.HRQ, bus.state}, 32'h9);
    wait_dack(1, 20); set_dreq(4'b1000);
    wait_dack(3, 20); set_dreq(4'b0000);
    wait_done("fixed", 30);

    // No HLDA: hold in S0, then request vanishes -> IDLE.
    bus.HLDA = 1'b0; set_dreq(4'b0100);
    repeat (3) @(posedge clk); #1;
    check("s0_hold", {27'd0, bus.HRQ, bus.AEN, bus.state}, 32'h11);
    set_dreq(4'b0000);
    @(posedge clk); #1;
    check("s0_vanish", {28'd0, bus.HRQ, bus.state}, 32'd0);
    bus.HLDA = 1'b1;

    // Rotating priority: 0,1,2,3,0.
    bus.commandReg = 8'h10;
    push_xfer(0, 1, 3); push_xfer(1, 1, 3); push_xfer(2, 1, 3);
    push_xfer(3, 1, 3); push_xfer(0, 1, 3);
    set_dreq(4'b1111);
    wait_dack(0, 20); wait_dack(1, 20); wait_dack(2, 20);
    wait_dack(3, 20); wait_dack(0, 20);
    set_dreq(4'b0000);
    wait_done("rotate", 30);
    bus.commandReg = 8'h00;

    // Block read, TC in the 4th S4: 12 contiguous transfer cycles.
    bus.mode_register = 8'h88;
    for (int i = 0; i < 4; i++) push_xfer(0, 2, 3);
    set_dreq(4'b0001);
    wait_dack(0, 20);
    n = 0; s4 = 0;
    while (bus.state !== 3'd0 && n < 40) begin
      if (bus.state === 3'd5) begin
        s4++;
        if (s4 == 4) begin bus.TC = 1'b1; set_dreq(4'b0000); end
      end
      @(posedge clk); #1; bus.TC = 1'b0; n++;
    end
    check("block_len", n, 32'd12);
    wait_done("block", 30);

    // Demand write: DREQ2 dropped during 2nd transfer -> exactly two.
    bus.mode_register = 8'h04;
    push_xfer(2, 1, 3); push_xfer(2, 1, 3);
    set_dreq(4'b0100);
    wait_dack(2, 20);
    wait_state(3'd5, 10); wait_state(3'd3, 10);
    set_dreq(4'b0000);
    wait_done("demand", 30);

    // All masked -> no HRQ; software request on channel 2 still served.
    bus.mode_register = 8'h44; bus.maskReg = 4'hF; set_dreq(4'b1111);
    repeat (5) @(posedge clk); #1;
    check("mask_blocks", {28'd0, bus.HRQ, bus.state}, 32'd0);
    bus.requestReg = 4'b0100;
    push_xfer(2, 1, 3);
    wait_dack(2, 20);
    bus.requestReg = 4'b0000; set_dreq(4'b0000);
    wait_done("swreq", 30);
    bus.maskReg = 4'h0;

    // HLDA dropped in S3.
    set_dreq(4'b0001);
    push_xfer(0, 1, 2);
    wait_state(3'd4, 20);
    bus.HLDA = 1'b0; set_dreq(4'b0000);
    @(posedge clk); #1;
    check("hlda_abort", {bus.HRQ, bus.AEN, dack_obs, strb_obs, bus.state}, 32'd0);
    check("hlda_abort_drained", exp_q.size(), 32'd0);
    bus.HLDA = 1'b1;

    // Reset asserted in S2 on channel 1.
    set_dreq(4'b0010);
    push_xfer(1, 1, 1);
    wait_state(3'd3, 20);
    rst_n = 1'b0; set_dreq(4'b0000);
    @(posedge clk); #1;
    check("reset_abort", {bus.HRQ, bus.AEN, dack_obs, strb_obs, bus.state,
                          bus.active_channel}, 32'd0);
    check("reset_abort_drained", exp_q.size(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_priority_control.md
DMA_PRIORITY_CONTROL -- requirements
Module: dma_priority_control

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk.
REQ-003 DREQ0..DREQ3  input  1 each  channel hardware requests, active-high, level-sensitive.
REQ-004 HLDA  input  1  hold acknowledge from CPU, active-high.
REQ-005 commandReg  input  8  command register; bit2 = controller disable, bit4 = rotating priority; other bits ignored.
REQ-006 maskReg  input  4  per-channel mask; bit n=1 blocks DREQn.
REQ-007 requestReg  input  4  per-channel software request; bit n=1 requests channel n regardless of mask.
REQ-008 mode_register  input  8  bits[3:2] transfer type (00 verify, 01 write, 10 read, 11 illegal); bits[7:6] mode (00 demand, 01 single, 10 block, 11 treated as single).
REQ-009 TC  input  1  terminal count from address/count stage, active-high.
REQ-010 HRQ  output  1  hold request to CPU.
REQ-011 DACK0..DACK3  output  1 each  channel acknowledges, active-high, at most one asserted.
REQ-012 AEN  output  1  address enable, high while controller owns the bus.
REQ-013 MEMR, MEMW, IOR, IOW  output  1 each  active-high transfer strobes.
REQ-014 active_channel  output  2  index of latched serviced channel.
REQ-015 state  output  3  FSM state encoding: IDLE=0, S0=1, S1=2, S2=3, S3=4, S4=5.

Function
REQ-016 Effective request vector: req[n] = (DREQn & ~maskReg[n]) | requestReg[n]; none valid when commandReg[2]=1.
REQ-017 Fixed priority (commandReg[4]=0): channel 0 highest, 3 lowest.
REQ-018 Rotating priority (commandReg[4]=1): after a service ends, the serviced channel becomes lowest, the next-higher index (mod 4) highest; pointer resets to channel 0 highest.
REQ-019 IDLE: HRQ=0, AEN=0, DACKs=0; if any req, go S0 next edge with HRQ=1.
REQ-020 S0: HRQ held 1; on HLDA=1 go S1 and latch winner into active_channel, using req sampled in that cycle; if req becomes empty before HLDA, return IDLE, HRQ=0.
REQ-021 S1: AEN=1, one cycle, then S2.
REQ-022 S2: DACK[active_channel]=1; read-side strobe asserted (write type: IOR; read type: MEMR); then S3.
REQ-023 S3: DACK held; read-side strobe held; write-side strobe asserted (write type: MEMW; read type: IOW); then S4.
REQ-024 Verify and illegal types: no strobes asserted; FSM timing unchanged.
REQ-025 S4: DACK held, strobes deasserted; next state: TC=1 -> IDLE; single -> IDLE; block -> S2; demand -> S2 if DREQ[active_channel] still 1 and not masked, else IDLE.
REQ-026 Leaving S4 to IDLE: HRQ, AEN, DACKs drop on same edge; rotating pointer updated on that edge.
REQ-027 HLDA falling in S1..S4: go IDLE next edge, all outputs deasserted; service counted as ended for rotation.
REQ-028 commandReg[2] set mid-transfer: current transfer completes through S4, then IDLE.
REQ-029 Mask or DREQ changes after channel latch do not change active_channel until return to IDLE.
REQ-030 Transfer cycle = 3 clocks (S2,S3,S4); bus acquisition latency DREQ->DACK = 3 clocks plus HLDA wait.
REQ-031 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-032 rst_n=0 at rising edge: state=IDLE, HRQ=0, AEN=0, DACK0..3=0, strobes=0, active_channel=0, rotation pointer = channel 0 highest.
REQ-033 Reset asserted mid-transfer aborts immediately; no strobe or DACK survives the reset edge.

Verification
REQ-034 Fixed priority: mask=0, DREQ1 and DREQ3 high, HLDA tied 1, single mode -> HRQ after 1 clk, DACK1 high S2..S4, then after IDLE DACK3 serviced.
REQ-035 Rotating: commandReg=8'h10, DREQ0..3 all high, single mode -> DACK order 0,1,2,3,0.
REQ-036 Block mode, read type (mode=8'h88), TC pulsed at 4th S4 -> 4 transfers, MEMR high 2 clks and IOW 1 clk per transfer, DACK0 continuous, then IDLE.
REQ-037 Demand mode (mode=8'h04): DREQ2 dropped during 2nd transfer -> exit to IDLE after that S4, IOR/MEMW pulsed exactly twice.
REQ-038 Masking/software request: maskReg=4'hF with DREQ0..3 high -> HRQ stays 0; then requestReg=4'b0100 -> DACK2 served.
REQ-039 Abort: HLDA dropped in S3 -> all outputs 0 next edge; rst_n low in S2 -> all outputs 0 after that edge, state=0.
